// File: rtl/mem_arbiter.sv
// Two-requester (icache/dcache) arbiter sharing a single main-memory port.
// One transaction in flight; ties alternate against the previous grant.
module mem_arbiter #(
   parameter int MEM_ADDR_BITS = 28,
   parameter int RESP_BEATS    = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ic_req_valid,
   output logic                     ic_req_ready,
   input  logic [MEM_ADDR_BITS-1:0] ic_req_addr,
   input  logic                     ic_req_rw,
   input  logic                     ic_req_data_valid,
   output logic                     ic_req_data_ready,
   input  logic [127:0]             ic_req_data_bits,
   input  logic [15:0]              ic_req_data_mask,
   output logic                     ic_resp_valid,
   output logic [127:0]             ic_resp_data,
   input  logic                     dc_req_valid,
   output logic                     dc_req_ready,
   input  logic [MEM_ADDR_BITS-1:0] dc_req_addr,
   input  logic                     dc_req_rw,
   input  logic                     dc_req_data_valid,
   output logic                     dc_req_data_ready,
   input  logic [127:0]             dc_req_data_bits,
   input  logic [15:0]              dc_req_data_mask,
   output logic                     dc_resp_valid,
   output logic [127:0]             dc_resp_data,
   output logic                     mem_req_valid,
   input  logic                     mem_req_ready,
   output logic                     mem_req_rw,
   output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
   output logic                     mem_req_data_valid,
   input  logic                     mem_req_data_ready,
   output logic [127:0]             mem_req_data_bits,
   output logic [15:0]              mem_req_data_mask,
   input  logic                     mem_resp_valid,
   input  logic [127:0]             mem_resp_data
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ADDR  = 2'd1;
   localparam logic [1:0] WDATA = 2'd2;
   localparam logic [1:0] RDATA = 2'd3;

   localparam logic OWN_IC = 1'b0;
   localparam logic OWN_DC = 1'b1;

   localparam int CNT_W = (RESP_BEATS > 1) ? $clog2(RESP_BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RESP_BEATS - 1);

   logic [1:0]       state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_grant_q, last_grant_d;
   logic [CNT_W-1:0] beat_q, beat_d;

   logic                     own_valid_s;
   logic                     own_rw_s;
   logic [MEM_ADDR_BITS-1:0] own_addr_s;
   logic                     own_data_valid_s;
   logic [127:0]             own_data_bits_s;
   logic [15:0]              own_data_mask_s;
   logic                     grant_s;

   assign own_valid_s      = (owner_q == OWN_DC) ? dc_req_valid      : ic_req_valid;
   assign own_rw_s         = (owner_q == OWN_DC) ? dc_req_rw         : ic_req_rw;
   assign own_addr_s       = (owner_q == OWN_DC) ? dc_req_addr       : ic_req_addr;
   assign own_data_valid_s = (owner_q == OWN_DC) ? dc_req_data_valid : ic_req_data_valid;
   assign own_data_bits_s  = (owner_q == OWN_DC) ? dc_req_data_bits  : ic_req_data_bits;
   assign own_data_mask_s  = (owner_q == OWN_DC) ? dc_req_data_mask  : ic_req_data_mask;

   assign ic_resp_data = mem_resp_data;
   assign dc_resp_data = mem_resp_data;

   // Grant choice in IDLE: a lone requester wins, a tie goes against last_grant
   always_comb begin
      if (dc_req_valid && !ic_req_valid) begin
         grant_s = OWN_DC;
      end else if (ic_req_valid && !dc_req_valid) begin
         grant_s = OWN_IC;
      end else begin
         grant_s = ~last_grant_q;
      end
   end

   // Next-state logic for the transaction FSM, owner, fairness and beat count
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      beat_d       = beat_q;
      case (state_q)
         IDLE: begin
            if (ic_req_valid || dc_req_valid) begin
               owner_d      = grant_s;
               last_grant_d = grant_s;
               state_d      = ADDR;
            end else begin
               state_d = IDLE;
            end
         end
         ADDR: begin
            if (!own_valid_s) begin
               state_d = IDLE;
            end else if (mem_req_ready) begin
               state_d = own_rw_s ? WDATA : RDATA;
               beat_d  = '0;
            end else begin
               state_d = ADDR;
            end
         end
         WDATA: begin
            if (own_data_valid_s && mem_req_data_ready) begin
               state_d = IDLE;
            end else begin
               state_d = WDATA;
            end
         end
         RDATA: begin
            if (mem_resp_valid) begin
               if (beat_q == LAST_BEAT) begin
                  beat_d  = '0;
                  state_d = IDLE;
               end else begin
                  beat_d = beat_q + CNT_W'(1);
               end
            end else begin
               state_d = RDATA;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Port steering: memory side mirrors the owner only in the matching phase
   always_comb begin
      ic_req_ready       = 1'b0;
      dc_req_ready       = 1'b0;
      ic_req_data_ready  = 1'b0;
      dc_req_data_ready  = 1'b0;
      ic_resp_valid      = 1'b0;
      dc_resp_valid      = 1'b0;
      mem_req_valid      = 1'b0;
      mem_req_rw         = 1'b0;
      mem_req_addr       = '0;
      mem_req_data_valid = 1'b0;
      mem_req_data_bits  = 128'd0;
      mem_req_data_mask  = 16'd0;
      case (state_q)
         ADDR: begin
            mem_req_valid = own_valid_s;
            mem_req_rw    = own_rw_s;
            mem_req_addr  = own_addr_s;
            if (owner_q == OWN_DC) begin
               dc_req_ready = mem_req_ready;
            end else begin
               ic_req_ready = mem_req_ready;
            end
         end
         WDATA: begin
            mem_req_data_valid = own_data_valid_s;
            mem_req_data_bits  = own_data_bits_s;
            mem_req_data_mask  = own_data_mask_s;
            if (owner_q == OWN_DC) begin
               dc_req_data_ready = mem_req_data_ready;
            end else begin
               ic_req_data_ready = mem_req_data_ready;
            end
         end
         RDATA: begin
            if (owner_q == OWN_DC) begin
               dc_resp_valid = mem_resp_valid;
            end else begin
               ic_resp_valid = mem_resp_valid;
            end
         end
         default: begin
            mem_req_valid = 1'b0;
         end
      endcase
   end

   // State registers; reset abandons any in-flight transaction
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= OWN_IC;
         last_grant_q <= OWN_IC;
         beat_q       <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         beat_q       <= beat_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: arbitration order, read/write phases,
// mid-transaction reset and stray/abandoned request handling.
module tb_mem_arbiter;

   logic         clk;
   logic         reset;
   logic         ic_req_valid, ic_req_ready, ic_req_rw;
   logic [27:0]  ic_req_addr;
   logic         ic_req_data_valid, ic_req_data_ready;
   logic [127:0] ic_req_data_bits;
   logic [15:0]  ic_req_data_mask;
   logic         ic_resp_valid;
   logic [127:0] ic_resp_data;
   logic         dc_req_valid, dc_req_ready, dc_req_rw;
   logic [27:0]  dc_req_addr;
   logic         dc_req_data_valid, dc_req_data_ready;
   logic [127:0] dc_req_data_bits;
   logic [15:0]  dc_req_data_mask;
   logic         dc_resp_valid;
   logic [127:0] dc_resp_data;
   logic         mem_req_valid, mem_req_ready, mem_req_rw;
   logic [27:0]  mem_req_addr;
   logic         mem_req_data_valid, mem_req_data_ready;
   logic [127:0] mem_req_data_bits;
   logic [15:0]  mem_req_data_mask;
   logic         mem_resp_valid;
   logic [127:0] mem_resp_data;

   int tests;
   int fails;

   mem_arbiter #(.MEM_ADDR_BITS(28), .RESP_BEATS(4)) dut (
      .clk(clk), .reset(reset),
      .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready),
      .ic_req_addr(ic_req_addr), .ic_req_rw(ic_req_rw),
      .ic_req_data_valid(ic_req_data_valid), .ic_req_data_ready(ic_req_data_ready),
      .ic_req_data_bits(ic_req_data_bits), .ic_req_data_mask(ic_req_data_mask),
      .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
      .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
      .dc_req_addr(dc_req_addr), .dc_req_rw(dc_req_rw),
      .dc_req_data_valid(dc_req_data_valid), .dc_req_data_ready(dc_req_data_ready),
      .dc_req_data_bits(dc_req_data_bits), .dc_req_data_mask(dc_req_data_mask),
      .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
      .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
      .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1;
      ic_req_valid = 1'b0; ic_req_addr = 28'd0; ic_req_rw = 1'b0;
      ic_req_data_valid = 1'b0; ic_req_data_bits = 128'd0; ic_req_data_mask = 16'd0;
      dc_req_valid = 1'b0; dc_req_addr = 28'd0; dc_req_rw = 1'b0;
      dc_req_data_valid = 1'b0; dc_req_data_bits = 128'd0; dc_req_data_mask = 16'd0;
      mem_req_ready = 1'b0; mem_req_data_ready = 1'b0;
      mem_resp_valid = 1'b0; mem_resp_data = 128'd0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state, then both requesters valid: dcache wins first
      dc_req_valid = 1'b1; dc_req_addr = 28'h0000010;
      ic_req_valid = 1'b1; ic_req_addr = 28'h0000020;
      #1;
      chk("idle_mem_req_valid", 128'(mem_req_valid), 128'd0);
      chk("idle_mem_req_addr", 128'(mem_req_addr), 128'd0);
      chk("idle_ic_ready", 128'(ic_req_ready), 128'd0);
      chk("idle_dc_ready", 128'(dc_req_ready), 128'd0);
      tick();
      chk("s1_mem_req_valid", 128'(mem_req_valid), 128'd1);
      chk("s1_mem_req_addr", 128'(mem_req_addr), 128'h10);
      chk("s1_dc_ready_wait", 128'(dc_req_ready), 128'd0);
      mem_req_ready = 1'b1;
      #1;
      chk("s1_dc_ready", 128'(dc_req_ready), 128'd1);
      chk("s1_ic_ready", 128'(ic_req_ready), 128'd0);
      tick();
      dc_req_valid = 1'b0; mem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mem_resp_valid = 1'b1; mem_resp_data = 128'h100 + 128'(i);
         #1;
         chk("s1_dc_resp_valid", 128'(dc_resp_valid), 128'd1);
         chk("s1_ic_resp_valid", 128'(ic_resp_valid), 128'd0);
         chk("s1_dc_resp_data", dc_resp_data, 128'h100 + 128'(i));
         tick();
      end
      mem_resp_valid = 1'b0;
      #1;
      chk("s1_gap_idle", 128'(mem_req_valid), 128'd0);
      tick();
      chk("s1_ic_addr", 128'(mem_req_addr), 128'h20);
      chk("s1_ic_valid", 128'(mem_req_valid), 128'd1);
      mem_req_ready = 1'b1;
      #1;
      chk("s1_ic_ready", 128'(ic_req_ready), 128'd1);
      chk("s1_dc_ready_off", 128'(dc_req_ready), 128'd0);
      tick();
      ic_req_valid = 1'b0; mem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mem_resp_valid = 1'b1; mem_resp_data = 128'h200 + 128'(i);
         #1;
         chk("s1_ic_resp_valid", 128'(ic_resp_valid), 128'd1);
         chk("s1_dc_resp_quiet", 128'(dc_resp_valid), 128'd0);
         tick();
      end
      mem_resp_valid = 1'b0;

      // dcache write with data acceptance delayed three cycles
      dc_req_valid = 1'b1; dc_req_addr = 28'h0000040; dc_req_rw = 1'b1;
      dc_req_data_valid = 1'b1; dc_req_data_bits = 128'h1; dc_req_data_mask = 16'h000F;
      ic_req_data_valid = 1'b1; ic_req_data_mask = 16'hFFFF;
      #1;
      tick();
      chk("s2_mem_rw", 128'(mem_req_rw), 128'd1);
      chk("s2_mem_addr", 128'(mem_req_addr), 128'h40);
      chk("s2_data_valid_in_addr", 128'(mem_req_data_valid), 128'd0);
      mem_req_ready = 1'b1;
      #1;
      chk("s2_ic_ready", 128'(ic_req_ready), 128'd0);
      tick();
      dc_req_valid = 1'b0; mem_req_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("s2_mem_data_valid", 128'(mem_req_data_valid), 128'd1);
         chk("s2_no_mem_req_valid", 128'(mem_req_valid), 128'd0);
         chk("s2_mask", 128'(mem_req_data_mask), 128'h000F);
         chk("s2_bits", mem_req_data_bits, 128'h1);
         chk("s2_dc_data_ready_wait", 128'(dc_req_data_ready), 128'd0);
         chk("s2_ic_ready_wdata", 128'(ic_req_ready), 128'd0);
         tick();
      end
      mem_req_data_ready = 1'b1;
      #1;
      chk("s2_dc_data_ready", 128'(dc_req_data_ready), 128'd1);
      chk("s2_ic_data_ready", 128'(ic_req_data_ready), 128'd0);
      tick();
      chk("s2_dc_data_ready_after", 128'(dc_req_data_ready), 128'd0);
      chk("s2_mask_idle", 128'(mem_req_data_mask), 128'd0);
      dc_req_data_valid = 1'b0; ic_req_data_valid = 1'b0; ic_req_data_mask = 16'd0;
      mem_req_data_ready = 1'b0; dc_req_rw = 1'b0;

      // Back-to-back contention alternates grants starting with dcache
      reset = 1'b1;
      tick();
      reset = 1'b0;
      dc_req_valid = 1'b1; dc_req_addr = 28'h0000050;
      ic_req_valid = 1'b1; ic_req_addr = 28'h0000060;
      mem_req_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("s3_dc_grant", 128'(dc_req_ready), (k % 2 == 0) ? 128'd1 : 128'd0);
         chk("s3_ic_grant", 128'(ic_req_ready), (k % 2 == 0) ? 128'd0 : 128'd1);
         chk("s3_addr", 128'(mem_req_addr), (k % 2 == 0) ? 128'h50 : 128'h60);
         tick();
         mem_resp_valid = 1'b1;
         repeat (4) tick();
         mem_resp_valid = 1'b0;
      end
      dc_req_valid = 1'b0; ic_req_valid = 1'b0; mem_req_ready = 1'b0;
      tick();

      // Reset after two of four beats; late beats must be ignored
      dc_req_valid = 1'b1; dc_req_addr = 28'h0000070;
      #1;
      tick();
      mem_req_ready = 1'b1;
      #1;
      tick();
      dc_req_valid = 1'b0; mem_req_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mem_resp_valid = 1'b1;
         #1;
         chk("s4_dc_beat", 128'(dc_resp_valid), 128'd1);
         tick();
      end
      mem_resp_valid = 1'b0; reset = 1'b1;
      #1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mem_resp_valid = 1'b1;
         #1;
         chk("s4_dc_late_beat", 128'(dc_resp_valid), 128'd0);
         chk("s4_ic_late_beat", 128'(ic_resp_valid), 128'd0);
         chk("s4_idle_after_reset", 128'(mem_req_valid), 128'd0);
         tick();
      end
      mem_resp_valid = 1'b0;
      ic_req_valid = 1'b1; ic_req_addr = 28'h0000080;
      #1;
      tick();
      chk("s4_ic_addr", 128'(mem_req_addr), 128'h80);
      mem_req_ready = 1'b1;
      #1;
      chk("s4_ic_ready", 128'(ic_req_ready), 128'd1);
      tick();
      ic_req_valid = 1'b0; mem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mem_resp_valid = 1'b1;
         #1;
         chk("s4_ic_beat", 128'(ic_resp_valid), 128'd1);
         tick();
      end
      chk("s4_beats_done", 128'(ic_resp_valid), 128'd0);

      // Stray beat in IDLE, then abandoned address phase keeps last_grant
      chk("s5_stray_dc", 128'(dc_resp_valid), 128'd0);
      tick();
      chk("s5_stray_idle", 128'(mem_req_valid), 128'd0);
      mem_resp_valid = 1'b0;
      dc_req_valid = 1'b1; dc_req_addr = 28'h0000090;
      #1;
      tick();
      chk("s5_dc_addr_phase", 128'(mem_req_valid), 128'd1);
      dc_req_valid = 1'b0;
      #1;
      chk("s5_drop_valid", 128'(mem_req_valid), 128'd0);
      tick();
      dc_req_valid = 1'b1; ic_req_valid = 1'b1; ic_req_addr = 28'h00000A0;
      #1;
      chk("s5_back_idle", 128'(mem_req_valid), 128'd0);
      tick();
      chk("s5_ic_wins_tie", 128'(mem_req_addr), 128'hA0);
      chk("s5_dc_not_ready", 128'(dc_req_ready), 128'd0);
      dc_req_valid = 1'b0; ic_req_valid = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_ADDR_BITS, default 28, main-memory line address width.
REQ-002 SHALL have parameter RESP_BEATS, default 4, mem_resp_valid beats returned per read.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 ic_req_valid / dc_req_valid  in  1 each  requester (icache / dcache) address request.
REQ-006 ic_req_ready / dc_req_ready  out  1 each  address request accepted.
REQ-007 ic_req_addr / dc_req_addr  in  MEM_ADDR_BITS each  line address.
REQ-008 ic_req_rw / dc_req_rw  in  1 each  1 = write, 0 = read.
REQ-009 ic_req_data_valid / dc_req_data_valid  in  1 each  write data offered.
REQ-010 ic_req_data_ready / dc_req_data_ready  out  1 each  write data accepted.
REQ-011 ic_req_data_bits / dc_req_data_bits  in  128 each  write data.
REQ-012 ic_req_data_mask / dc_req_data_mask  in  16 each  byte write mask.
REQ-013 ic_resp_valid / dc_resp_valid  out  1 each  read beat for that requester.
REQ-014 ic_resp_data / dc_resp_data  out  128 each  read beat data.
REQ-015 mem_req_valid, mem_req_rw  out  1 each; mem_req_ready  in  1; mem_req_addr  out  MEM_ADDR_BITS.
REQ-016 mem_req_data_valid  out  1; mem_req_data_ready  in  1; mem_req_data_bits  out  128; mem_req_data_mask  out  16.
REQ-017 mem_resp_valid  in  1; mem_resp_data  in  128.

Function
REQ-018 SHALL share one main-memory port between icache and dcache, one transaction in flight at a time.
REQ-019 SHALL implement states IDLE, ADDR, WDATA, RDATA; owner register (IC/DC); last_grant register; beat counter of ceilLog2(RESP_BEATS) bits.
REQ-020 IDLE: only dc_req_valid -> owner=DC; only ic_req_valid -> owner=IC; both -> owner = requester not equal last_grant; next state ADDR; last_grant<=owner.
REQ-021 IDLE: all ready/valid outputs toward memory and requesters SHALL be 0; requester valid at cycle t gives mem_req_valid at t+1.
REQ-022 ADDR: mem_req_valid/addr/rw SHALL combinationally equal owner's req_valid/addr/rw; owner req_ready = mem_req_ready; non-owner req_ready = 0.
REQ-023 ADDR: on mem_req_valid & mem_req_ready, rw=1 -> WDATA, rw=0 -> RDATA with beat counter cleared.
REQ-024 ADDR: owner req_valid low -> return to IDLE next cycle (grant released, last_grant kept).
REQ-025 WDATA: mem_req_data_valid/bits/mask SHALL equal owner's; owner data_ready = mem_req_data_ready; on handshake -> IDLE.
REQ-026 data_ready SHALL be 0 to both requesters outside WDATA and to non-owner always.
REQ-027 RDATA: owner resp_valid = mem_resp_valid; non-owner resp_valid = 0; ic_resp_data and dc_resp_data = mem_resp_data always.
REQ-028 RDATA: each mem_resp_valid increments counter; beat RESP_BEATS-1 -> IDLE, counter wraps to 0.
REQ-029 mem_resp_valid outside RDATA SHALL be ignored (no resp_valid asserted, no state change).
REQ-030 mem_req_valid and mem_req_data_valid SHALL never be asserted in the same cycle.
REQ-031 At least one IDLE cycle SHALL separate consecutive transactions.

Reset
REQ-032 reset=1 SHALL force state IDLE, last_grant=IC, counter=0, all valid/ready outputs 0 next cycle, mid-transaction included; beats arriving after reset ignored.
REQ-033 mem_req_addr/rw/data_bits/mask SHALL be 0 in IDLE and after reset.

Verification
REQ-034 Both valid in IDLE after reset, dc read addr 0x000_0010, ic read addr 0x000_0020 -> dc granted first, mem_req_addr=0x0000010, 4 beats to dc_resp only, then ic served.
REQ-035 dc write addr 0x0000040, data 128'h1, mask 16'h000F, mem_req_data_ready delayed 3 cycles -> dc_req_data_ready pulses once with it, mem_req_data_mask=16'h000F, ic_req_ready=0 throughout.
REQ-036 Both requesters continuously valid for 6 transactions -> grants alternate DC,IC,DC,IC,DC,IC.
REQ-037 reset asserted after 2 of 4 read beats -> all resp_valid 0, remaining 2 beats ignored, next ic request served normally.
REQ-038 Stray mem_resp_valid in IDLE and owner dropping req_valid in ADDR -> no resp_valid, return to IDLE, last_grant unchanged.
